tdm_demux4: RTL

- 1-to-4 time-division demultiplexer: the receive end of the 4-way mux path.
- Accepts one sample stream, where each frame is 4 consecutive valid slots and slot 0 is marked by frame_start.
- Distributes the slots to four held parallel outputs and issues a one-cycle frame_valid strobe per complete frame.
- Tracks frame alignment with a hunt/lock state machine.

---
 rtl/tdm_demux4_pkg.sv | 12 +
 rtl/tdm_demux4_if.sv | 29 ++
 rtl/tdm_demux4_frame_sync.sv | 78 +++++++
 rtl/tdm_demux4.sv | 60 ++++++
 4 files changed

// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the 4-way TDM demultiplexer.
package tdm_pkg;

  localparam int SLOTS = 4;

  // Slot index within a frame (0..SLOTS-1).
  typedef logic [1:0] slot_t;

  // Frame alignment state: searching for slot 0, or tracking frames.
  typedef enum logic {HUNT, LOCKED} tdm_state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Sample-stream input and parallel-lane output bundle of the demultiplexer.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);

  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic             frame_start;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic [WIDTH-1:0] q3;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;

  // Stream source / lane consumer side.
  modport master (
    output din_valid, din, frame_start,
    input  q0, q1, q2, q3, frame_valid, locked, sync_err
  );

  // Demultiplexer side.
  modport slave (
    input  din_valid, din, frame_start,
    output q0, q1, q2, q3, frame_valid, locked, sync_err
  );

endinterface

// File: rtl/tdm_demux4_frame_sync.sv
// Frame alignment FSM and slot counter. Produces per-cycle shadow write
// enables and a frame_done strobe for the slot-3 sample; sync_err is
// registered so it lines up with the data-path outputs.
module tdm_frame_sync
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [SLOTS-2:0] shadow_we,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked
);

  tdm_state_t state, next_state;
  slot_t      cnt, next_cnt;
  logic       sync_err_d;

  // State, slot counter and error pulse registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      cnt      <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      sync_err <= sync_err_d;
    end
  end

  // Next-state, counter and strobe decode; nothing moves without din_valid.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    shadow_we  = '0;
    frame_done = 1'b0;
    sync_err_d = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_start) begin
            shadow_we[0] = 1'b1;
            next_cnt     = slot_t'(1);
            next_state   = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_start) begin
            // A slot-0 mark mid-frame drops the partial frame and restarts.
            sync_err_d   = (cnt != '0);
            shadow_we[0] = 1'b1;
            next_cnt     = slot_t'(1);
          end else if (cnt == '0) begin
            sync_err_d = 1'b1;
            next_state = HUNT;
          end else if (cnt == slot_t'(SLOTS - 1)) begin
            frame_done = 1'b1;
            next_cnt   = '0;
          end else begin
            shadow_we[cnt] = 1'b1;
            next_cnt       = cnt + slot_t'(1);
          end
        end
        default: next_state = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demultiplexer: collects slots 0..2 in shadow registers and
// transfers the whole frame to the held output lanes on the slot-3 sample.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  tdm_demux4_if.slave    bus
);

  logic [SLOTS-2:0] shadow_we;
  logic             frame_done;
  logic [WIDTH-1:0] shadow [SLOTS-1];

  tdm_frame_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_valid   (bus.din_valid),
    .frame_start (bus.frame_start),
    .shadow_we   (shadow_we),
    .frame_done  (frame_done),
    .sync_err    (bus.sync_err),
    .locked      (bus.locked)
  );

  // Shadow bank: captures slots 0..2 of the frame in progress.
  // NOTE: this small register bank is reset on purpose so a reset mid-frame
  // discards partial data at once; a large RAM would normally not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS - 1; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < SLOTS - 1; i++) begin
        if (shadow_we[i]) shadow[i] <= bus.din;
      end
    end
  end

  // Output bank and frame strobe: updated together when slot 3 arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.q0          <= '0;
      bus.q1          <= '0;
      bus.q2          <= '0;
      bus.q3          <= '0;
      bus.frame_valid <= 1'b0;
    end else begin
      bus.frame_valid <= frame_done;
      if (frame_done) begin
        bus.q0 <= shadow[0];
        bus.q1 <= shadow[1];
        bus.q2 <= shadow[2];
        bus.q3 <= bus.din;
      end
    end
  end

endmodule
